fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined ARMv8 core. It owns the program counter and drives the instruction-memory address. It captures the fetched word into the IF/ID pipeline register for the decode stage, and applies stall and redirect (branch/flush) requests from downstream. An optional static predictor lets CB-type and B instructions redirect fetch with zero bubbles.

## Interface
- PC_W, 64, program-counter width in bits
- RESET_PC, 0, PC value loaded on reset
- clock  input  1  rising-edge clock; the only clock domain
- reset  input  1  synchronous, active-low reset
- imem_addr  output  PC_W  byte address of the instruction being fetched; equals the PC register
- imem_rdata  input  32  instruction word at imem_addr, combinational (same-cycle) read
- stall  input  1  hazard-unit request to hold the PC and IF/ID
- redirect_valid  input  1  downstream resolved a control-flow mismatch; flush and refetch
- redirect_pc  input  PC_W  correct next PC, sampled when redirect_valid=1
- ifid_valid  output  1  IF/ID holds a real instruction
- ifid_pc  output  PC_W  PC of ifid_instr
- ifid_pc_plus4  output  PC_W  ifid_pc+4, used as the BL link value
- ifid_instr  output  32  instruction word; 32'h0 when invalid
- ifid_pred_taken  output  1  fetch predicted this instruction taken; always 0 without the macro

## Operation
- PC register next-value priority: reset > redirect_valid > stall > predicted target > PC+4.
- All PC arithmetic is modulo 2^PC_W; PC+4 from the last word of the address space wraps to 0.
- IF/ID update, evaluated per clock edge:
  - redirect_valid=1: ifid_valid=0, ifid_instr=0, ifid_pred_taken=0; pc fields are don't-care but are driven 0.
  - else stall=1: all ifid_* fields hold.
  - else: capture ifid_valid=1, ifid_pc=PC, ifid_pc_plus4=PC+4, ifid_instr=imem_rdata, and the prediction bit.
- redirect_valid together with stall: the redirect wins; the PC loads redirect_pc and IF/ID flushes.
- Reset (reset=0 at an edge): PC=RESET_PC; ifid_valid=0; ifid_pc=0; ifid_pc_plus4=0; ifid_instr=0; ifid_pred_taken=0.
  - Reset overrides stall and redirect.
  - Asserting reset mid-stream discards the in-flight fetch.
- imem_addr follows the PC register combinationally, so it reads RESET_PC throughout reset.
- Downstream compares its resolved outcome against ifid_pred_taken (carried down the pipe) and asserts redirect_valid with the correct PC on any mismatch. This stage does not track which instructions were predicted.

## Timing
- Fetch-to-IF/ID latency is 1 cycle: the word read at cycle n appears on ifid_* in cycle n+1.
- Redirect asserted in cycle n:
  - imem_addr=redirect_pc in cycle n+1;
  - ifid_valid=0 in cycle n+1;
  - the redirected word appears in IF/ID in cycle n+2.
- Stall held for k cycles: imem_addr and ifid_* stay constant for k cycles and resume on the first cycle with stall=0.
- Predicted-taken branch fetched at cycle n: imem_addr equals the target in cycle n+1, with no bubble.
- First edge with reset=1 captures the word at RESET_PC; ifid_valid=1 from the following cycle.

## Configuration
- FETCH_STATIC_PREDICT_EN defined: a predecode of imem_rdata is applied only when stall=0 and redirect_valid=0.
  - B (bits[31:26]=6'b000101): always predicted taken, target PC+sext(imm26)<<2.
  - CBZ/CBNZ (bits[31:24]=8'hB4/8'hB5): predicted taken only when imm19 is negative (backward), target PC+sext(imm19)<<2.
  - ifid_pred_taken=1 for every predicted-taken instruction.
- FETCH_STATIC_PREDICT_EN undefined:
  - next PC is always PC+4 absent a redirect;
  - ifid_pred_taken is tied to 0;
  - the predecode logic is not instantiated.

## Structure
- The shared package armv8_pipeline_pkg holds:
  - the PC_W default;
  - NOP_INSTR=32'h0;
  - opcode constants OP_CBZ=8'hB4, OP_CBNZ=8'hB5, OP_B=6'b000101;
  - a typedef for the IF/ID record (valid, pc, pc_plus4, instr, pred_taken).
- Sub-module branch_predecode: combinational; inputs instr and pc; outputs is_pred_taken and target.
- branch_predecode is instantiated only under FETCH_STATIC_PREDICT_EN.

## Test plan
- Reset and sequential fetch: reset=0 for 2 cycles with RESET_PC=0.
  - During reset: imem_addr=0, ifid_valid=0.
  - After release: imem_addr=0,4,8,… and ifid_pc=0,4,… one cycle later, with ifid_pc_plus4=ifid_pc+4.
- Stall: stall=1 for 2 cycles while imem_addr=0x8.
  - imem_addr stays 0x8, ifid_pc stays 0x4.
  - After release: 0xC, then 0x10.
- Redirect: redirect_valid=1, redirect_pc=0x40 while imem_addr=0x10.
  - Next cycle: imem_addr=0x40, ifid_valid=0, ifid_instr=0.
  - Cycle after: ifid_pc=0x40, imem_addr=0x44.
- Simultaneous stall and redirect (redirect_pc=0x80): imem_addr=0x80 next cycle and IF/ID flushed.
  - A reset in the same cycle instead yields imem_addr=RESET_PC.
- Prediction (macro on):
  - CBNZ with imm19=-4 at 0x20: next imem_addr=0x10, ifid_pred_taken=1.
  - CBZ with imm19=+4 at 0x30: next imem_addr=0x34, ifid_pred_taken=0.
  - B with imm26=+2 at 0x40: next imem_addr=0x48.
  - Macro off: all three fall through (0x24/0x34/0x44), ifid_pred_taken=0.
- Wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC.
  - After release: imem_addr=0 next.
  - ifid_pc=64'hFFFF_FFFF_FFFF_FFFC with ifid_pc_plus4=0.

Source files
------------

// File: rtl/armv8_pipeline_pkg.sv
// Shared definitions for the ARMv8 pipeline: PC width default, NOP encoding,
// control-flow opcode constants used by fetch predecode, and the IF/ID record.
package armv8_pipeline_pkg;

    localparam int          PC_W_DEF  = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Opcode fields: CBZ/CBNZ live in bits[31:24], B in bits[31:26]
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [7:0]  OP_CBNZ = 8'hB5;
    localparam logic [5:0]  OP_B    = 6'b000101;

    // IF/ID pipeline record; pc fields sized for the widest supported PC
    typedef struct packed {
        logic                valid;
        logic [PC_W_DEF-1:0] pc;
        logic [PC_W_DEF-1:0] pc_plus4;
        logic [31:0]         instr;
        logic                pred_taken;
    } ifid_rec_t;

    // Empty (bubble) IF/ID contents, used on reset and on flush
    localparam ifid_rec_t IFID_EMPTY = '{
        valid:      1'b0,
        pc:         {PC_W_DEF{1'b0}},
        pc_plus4:   {PC_W_DEF{1'b0}},
        instr:      NOP_INSTR,
        pred_taken: 1'b0
    };

endpackage

// File: rtl/fetch_stage_branch_predecode.sv
// Static branch predecode: B is always taken, CBZ/CBNZ taken only when the
// displacement is negative (backward loop edge). Purely combinational.
module branch_predecode
    import armv8_pipeline_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [31:0]   instr,
    input  logic [PC_W-1:0] pc,
    output logic          is_pred_taken,
    output logic [PC_W-1:0] target
);

    logic [PC_W-1:0] w_off_b;
    logic [PC_W-1:0] w_off_cb;
    logic            w_is_b;
    logic            w_is_cb;

    // Sign-extended, word-scaled displacements for both branch formats
    assign w_off_b  = {{(PC_W-28){instr[25]}}, instr[25:0], 2'b00};
    assign w_off_cb = {{(PC_W-21){instr[23]}}, instr[23:5], 2'b00};
    assign w_is_b   = (instr[31:26] == OP_B);
    assign w_is_cb  = (instr[31:24] == OP_CBZ) || (instr[31:24] == OP_CBNZ);

    // Select prediction and target; fall-through reports not-taken with target pc
    always_comb begin
        is_pred_taken = 1'b0;
        target        = pc;
        if (w_is_b) begin
            is_pred_taken = 1'b1;
            target        = pc + w_off_b;
        end else if (w_is_cb && instr[23]) begin
            is_pred_taken = 1'b1;
            target        = pc + w_off_cb;
        end else begin
            is_pred_taken = 1'b0;
            target        = pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and fills the IF/ID register. Honors stall and redirect from downstream.
// Optional static prediction is enabled by defining FETCH_STATIC_PREDICT_EN.
module fetch_stage
    import armv8_pipeline_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clock,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            ifid_valid,
    output logic [PC_W-1:0] ifid_pc,
    output logic [PC_W-1:0] ifid_pc_plus4,
    output logic [31:0]     ifid_instr,
    output logic            ifid_pred_taken
);

    logic [PC_W-1:0] r_pc;
    ifid_rec_t       r_ifid;

    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_pc_next;
    ifid_rec_t       w_ifid_next;
    logic            w_pred_taken;
    logic [PC_W-1:0] w_pred_target;

    // PC+4 wraps naturally modulo 2^PC_W
    assign w_pc_plus4 = r_pc + {{(PC_W-3){1'b0}}, 3'd4};

`ifdef FETCH_STATIC_PREDICT_EN
    branch_predecode #(
        .PC_W (PC_W)
    ) u_predecode (
        .instr         (imem_rdata),
        .pc            (r_pc),
        .is_pred_taken (w_pred_taken),
        .target        (w_pred_target)
    );
`else
    assign w_pred_taken  = 1'b0;
    assign w_pred_target = w_pc_plus4;
`endif

    // Next PC and IF/ID contents: redirect beats stall beats prediction beats PC+4
    always_comb begin
        w_pc_next   = r_pc;
        w_ifid_next = r_ifid;
        if (redirect_valid) begin
            w_pc_next   = redirect_pc;
            w_ifid_next = IFID_EMPTY;
        end else if (stall) begin
            w_pc_next   = r_pc;
            w_ifid_next = r_ifid;
        end else begin
            if (w_pred_taken) begin
                w_pc_next = w_pred_target;
            end else begin
                w_pc_next = w_pc_plus4;
            end
            w_ifid_next.valid      = 1'b1;
            w_ifid_next.pc         = PC_W_DEF'(r_pc);
            w_ifid_next.pc_plus4   = PC_W_DEF'(w_pc_plus4);
            w_ifid_next.instr      = imem_rdata;
            w_ifid_next.pred_taken = w_pred_taken;
        end
    end

    // PC and IF/ID state; synchronous active-low reset discards any in-flight fetch
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc   <= RESET_PC;
            r_ifid <= IFID_EMPTY;
        end else begin
            r_pc   <= w_pc_next;
            r_ifid <= w_ifid_next;
        end
    end

    assign imem_addr       = r_pc;
    assign ifid_valid      = r_ifid.valid;
    assign ifid_pc         = r_ifid.pc[PC_W-1:0];
    assign ifid_pc_plus4   = r_ifid.pc_plus4[PC_W-1:0];
    assign ifid_instr      = r_ifid.instr;
    assign ifid_pred_taken = r_ifid.pred_taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. Two instances share stimulus:
// dut0 with RESET_PC=0 and dut1 with RESET_PC at the top word to exercise wrap.
// Prediction expectations follow FETCH_STATIC_PREDICT_EN as compiled.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        br_en;

    logic [63:0] a0_addr, a0_pc, a0_pc4, a1_addr, a1_pc, a1_pc4;
    logic [31:0] a0_rdata, a0_instr, a1_rdata, a1_instr;
    logic        a0_valid, a0_pt, a1_valid, a1_pt;

    int n_vec = 0;
    int n_err = 0;

`ifdef FETCH_STATIC_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    always #5 clock = ~clock;

    // Instruction memory: plain ALU-like words, plus branch words when br_en=1
    function automatic logic [31:0] imem_word(input logic [63:0] a, input logic br);
        if (br && a == 64'h20)      return 32'hB5FFFF80;   // CBNZ imm19=-4
        else if (br && a == 64'h30) return 32'hB4000080;   // CBZ  imm19=+4
        else if (br && a == 64'h40) return 32'h14000002;   // B    imm26=+2
        else                        return {8'hAA, a[23:0]};
    endfunction

    assign a0_rdata = imem_word(a0_addr, br_en);
    assign a1_rdata = imem_word(a1_addr, br_en);

    fetch_stage #(.PC_W(64), .RESET_PC(64'h0)) dut0 (
        .clock(clock), .reset(reset), .imem_addr(a0_addr), .imem_rdata(a0_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifid_valid(a0_valid), .ifid_pc(a0_pc), .ifid_pc_plus4(a0_pc4),
        .ifid_instr(a0_instr), .ifid_pred_taken(a0_pt));

    fetch_stage #(.PC_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut1 (
        .clock(clock), .reset(reset), .imem_addr(a1_addr), .imem_rdata(a1_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifid_valid(a1_valid), .ifid_pc(a1_pc), .ifid_pc_plus4(a1_pc4),
        .ifid_instr(a1_instr), .ifid_pred_taken(a1_pt));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0; br_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++; if (a0_addr !== 64'h0) begin n_err++; $display("FAIL reset_addr got %h exp %h", a0_addr, 64'h0); end
            n_vec++; if (a0_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", a0_valid); end
            n_vec++; if (a0_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h exp 0", a0_instr); end
            n_vec++; if (a0_pc !== 64'h0 || a0_pc4 !== 64'h0) begin n_err++; $display("FAIL reset_pcs got %h/%h exp 0/0", a0_pc, a0_pc4); end
            n_vec++; if (a1_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL reset_addr_wrap got %h exp fffffffffffffffc", a1_addr); end
        end
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        step();
        n_vec++; if (a1_addr !== 64'h0) begin n_err++; $display("FAIL wrap_addr got %h exp 0", a1_addr); end
        n_vec++; if (a1_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_pc got %h exp fffffffffffffffc", a1_pc); end
        n_vec++; if (a1_pc4 !== 64'h0) begin n_err++; $display("FAIL wrap_pc4 got %h exp 0", a1_pc4); end
        n_vec++; if (a1_valid !== 1'b1 || a1_instr !== 32'hAAFF_FFFC) begin n_err++; $display("FAIL wrap_capture got %b/%h exp 1/aafffffc", a1_valid, a1_instr); end
    endtask

    task automatic test_seq();
        // First post-release edge already taken by test_wrap
        n_vec++; if (a0_addr !== 64'h4) begin n_err++; $display("FAIL seq_addr0 got %h exp 4", a0_addr); end
        n_vec++; if (a0_valid !== 1'b1 || a0_pc !== 64'h0 || a0_pc4 !== 64'h4) begin n_err++; $display("FAIL seq_ifid0 got %b/%h/%h exp 1/0/4", a0_valid, a0_pc, a0_pc4); end
        n_vec++; if (a0_instr !== 32'hAA00_0000) begin n_err++; $display("FAIL seq_instr0 got %h exp aa000000", a0_instr); end
        n_vec++; if (a0_pt !== 1'b0) begin n_err++; $display("FAIL seq_pt0 got %b exp 0", a0_pt); end
        step();
        n_vec++; if (a0_addr !== 64'h8) begin n_err++; $display("FAIL seq_addr1 got %h exp 8", a0_addr); end
        n_vec++; if (a0_pc !== 64'h4 || a0_pc4 !== 64'h8 || a0_instr !== 32'hAA00_0004) begin n_err++; $display("FAIL seq_ifid1 got %h/%h/%h exp 4/8/aa000004", a0_pc, a0_pc4, a0_instr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++; if (a0_addr !== 64'h8) begin n_err++; $display("FAIL stall_addr got %h exp 8", a0_addr); end
            n_vec++; if (a0_pc !== 64'h4 || a0_valid !== 1'b1 || a0_instr !== 32'hAA00_0004) begin n_err++; $display("FAIL stall_ifid got %h/%b/%h exp 4/1/aa000004", a0_pc, a0_valid, a0_instr); end
        end
        stall = 1'b0;
        step();
        n_vec++; if (a0_addr !== 64'hC || a0_pc !== 64'h8) begin n_err++; $display("FAIL stall_rel1 got %h/%h exp c/8", a0_addr, a0_pc); end
        step();
        n_vec++; if (a0_addr !== 64'h10 || a0_pc !== 64'hC) begin n_err++; $display("FAIL stall_rel2 got %h/%h exp 10/c", a0_addr, a0_pc); end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        step();
        redirect_valid = 1'b0;
        n_vec++; if (a0_addr !== 64'h40) begin n_err++; $display("FAIL redir_addr got %h exp 40", a0_addr); end
        n_vec++; if (a0_valid !== 1'b0 || a0_instr !== 32'h0 || a0_pc !== 64'h0 || a0_pt !== 1'b0) begin n_err++; $display("FAIL redir_flush got %b/%h/%h/%b exp 0/0/0/0", a0_valid, a0_instr, a0_pc, a0_pt); end
        step();
        n_vec++; if (a0_pc !== 64'h40 || a0_valid !== 1'b1 || a0_addr !== 64'h44) begin n_err++; $display("FAIL redir_next got pc %h v %b addr %h exp 40/1/44", a0_pc, a0_valid, a0_addr); end
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h80;
        step();
        n_vec++; if (a0_addr !== 64'h80 || a0_valid !== 1'b0 || a0_instr !== 32'h0) begin n_err++; $display("FAIL stall_redir got %h/%b/%h exp 80/0/0", a0_addr, a0_valid, a0_instr); end
        step();
        reset = 1'b0;
        step();
        n_vec++; if (a0_addr !== 64'h0 || a0_valid !== 1'b0) begin n_err++; $display("FAIL reset_over_redir got %h/%b exp 0/0", a0_addr, a0_valid); end
        n_vec++; if (a1_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL reset_over_redir1 got %h exp fffffffffffffffc", a1_addr); end
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    endtask

    task automatic test_predict();
        logic [63:0] src [3];
        logic [63:0] exp_next [3];
        logic [31:0] exp_instr [3];
        logic        exp_pt [3];
        src[0] = 64'h20; exp_instr[0] = 32'hB5FFFF80; exp_next[0] = PRED ? 64'h10 : 64'h24; exp_pt[0] = PRED;
        src[1] = 64'h30; exp_instr[1] = 32'hB4000080; exp_next[1] = 64'h34;                 exp_pt[1] = 1'b0;
        src[2] = 64'h40; exp_instr[2] = 32'h14000002; exp_next[2] = PRED ? 64'h48 : 64'h44; exp_pt[2] = PRED;
        br_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            redirect_valid = 1'b1; redirect_pc = src[i];
            step();
            redirect_valid = 1'b0;
            n_vec++; if (a0_addr !== src[i]) begin n_err++; $display("FAIL pred_src%0d got %h exp %h", i, a0_addr, src[i]); end
            step();
            n_vec++; if (a0_addr !== exp_next[i]) begin n_err++; $display("FAIL pred_next%0d got %h exp %h", i, a0_addr, exp_next[i]); end
            n_vec++; if (a0_pt !== exp_pt[i]) begin n_err++; $display("FAIL pred_bit%0d got %b exp %b", i, a0_pt, exp_pt[i]); end
            n_vec++; if (a0_pc !== src[i] || a0_instr !== exp_instr[i]) begin n_err++; $display("FAIL pred_ifid%0d got %h/%h exp %h/%h", i, a0_pc, a0_instr, src[i], exp_instr[i]); end
        end
        br_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_seq();
        test_stall();
        test_redirect();
        test_stall_redirect();
        test_predict();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
